// File: rtl/mc8051_mem_ctrl_pkg.sv
// Shared types, widths and decode helpers for the 8051 memory-side controller.
package mc8051_mem_ctrl_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_CAPT  = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ACC_CODE = 2'd0,
      ACC_XRD  = 2'd1,
      ACC_XWR  = 2'd2
   } acc_e;

   localparam logic [DATA_W-1:0] OOR_FILL = 8'hFF;

   // Priority PSEN > RD > WE; only meaningful when at least one strobe is low.
   function automatic acc_e decode_acc(input logic psen_n, input logic rd_n, input logic we_n);
      acc_e acc;
      acc = ACC_XWR;
      if (!psen_n)    acc = ACC_CODE;
      else if (!rd_n) acc = ACC_XRD;
      else if (!we_n) acc = ACC_XWR;
      return acc;
   endfunction

   function automatic logic multi_low(input logic psen_n, input logic rd_n, input logic we_n);
      return (!psen_n && !rd_n) || (!psen_n && !we_n) || (!rd_n && !we_n);
   endfunction

endpackage

// File: rtl/mc8051_mem_ctrl_if.sv
// Core-side naive memory bus: level strobes in, level ready and read data out.
interface mc8051_mem_ctrl_if;
   import mc8051_mem_ctrl_pkg::*;

   logic              we_n;
   logic              rd_n;
   logic              psen_n;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              data_rdy;
   logic [DATA_W-1:0] rdata;

   modport master (
      output we_n, rd_n, psen_n, addr, wdata,
      input  data_rdy, rdata
   );

   modport slave (
      input  we_n, rd_n, psen_n, addr, wdata,
      output data_rdy, rdata
   );

endinterface

// File: rtl/mc8051_mem_ctrl_wait_cnt.sv
// 4-bit loadable down-counter for wait-state insertion; expire marks the last wait cycle.
module mc8051_mem_wait_cnt (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       expire_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= 4'd0;
      else          cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/mc8051_mem_ctrl.sv
// Memory-side controller: decodes core strobes into code-ROM / XRAM accesses on
// synchronous single-port memories, with wait states and a level ready handshake.
module mc8051_mem_ctrl
   import mc8051_mem_ctrl_pkg::*;
#(
   parameter int CODE_AW    = 12,
   parameter int XDATA_AW   = 11,
   parameter int CODE_WAIT  = 0,
   parameter int XDATA_WAIT = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   mc8051_mem_ctrl_if.slave    mem_if,
   output logic                rom_en_o,
   output logic [CODE_AW-1:0]  rom_addr_o,
   input  logic [DATA_W-1:0]   rom_rdata_i,
   output logic                ram_en_o,
   output logic                ram_we_o,
   output logic [XDATA_AW-1:0] ram_addr_o,
   output logic [DATA_W-1:0]   ram_wdata_o,
   input  logic [DATA_W-1:0]   ram_rdata_i,
   output logic                err_o
);

   if (CODE_WAIT < 0 || CODE_WAIT > 15) begin : g_code_wait_chk
      $error("CODE_WAIT must be in 0..15");
   end
   if (XDATA_WAIT < 0 || XDATA_WAIT > 15) begin : g_xdata_wait_chk
      $error("XDATA_WAIT must be in 0..15");
   end

   localparam logic [3:0]  CODE_WAIT_L  = 4'(CODE_WAIT);
   localparam logic [3:0]  XDATA_WAIT_L = 4'(XDATA_WAIT);
   localparam logic [16:0] CODE_LIMIT   = 17'd1 << CODE_AW;
   localparam logic [16:0] XDATA_LIMIT  = 17'd1 << XDATA_AW;

   state_e              state_q, state_d;
   acc_e                acc_q, acc_new;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                all_high, start, oor, wait_expire, capt_rd;
   logic [3:0]          wait_load;

   assign all_high  = mem_if.psen_n & mem_if.rd_n & mem_if.we_n;
   assign start     = (state_q == ST_IDLE) && !all_high;
   assign acc_new   = decode_acc(mem_if.psen_n, mem_if.rd_n, mem_if.we_n);
   assign wait_load = (acc_new == ACC_CODE) ? CODE_WAIT_L : XDATA_WAIT_L;

   // Range is judged on the full latched address, so truncation can never alias into memory.
   assign oor = (acc_q == ACC_CODE) ? ({1'b0, addr_q} >= CODE_LIMIT)
                                    : ({1'b0, addr_q} >= XDATA_LIMIT);

   mc8051_mem_wait_cnt u_wait_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (start),
      .load_val_i (wait_load),
      .dec_i      (state_q == ST_WAIT),
      .expire_o   (wait_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!all_high) state_d = (wait_load == 4'd0) ? ST_ISSUE : ST_WAIT;
         ST_WAIT:  if (all_high) state_d = ST_IDLE;
                   else if (wait_expire) state_d = ST_ISSUE;
         ST_ISSUE: state_d = all_high ? ST_IDLE : ST_CAPT;
         ST_CAPT:  state_d = all_high ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (all_high) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rom_en_o = (state_q == ST_ISSUE) && (acc_q == ACC_CODE) && !oor;
      ram_en_o = (state_q == ST_ISSUE) && (acc_q != ACC_CODE) && !oor;
      ram_we_o = ram_en_o && (acc_q == ACC_XWR);
      mem_if.data_rdy = (state_q == ST_HOLD);
   end

   // A released strobe in CAPT is an abort: the read data is discarded.
   assign capt_rd = (state_q == ST_CAPT) && !all_high && (acc_q != ACC_XWR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= ACC_CODE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= OOR_FILL;
         err_q   <= 1'b0;
      end else begin
         if (start) begin
            acc_q   <= acc_new;
            addr_q  <= mem_if.addr;
            wdata_q <= mem_if.wdata;
            if (multi_low(mem_if.psen_n, mem_if.rd_n, mem_if.we_n)) err_q <= 1'b1;
         end
         if (capt_rd) begin
            if (oor)                    rdata_q <= OOR_FILL;
            else if (acc_q == ACC_CODE) rdata_q <= rom_rdata_i;
            else                        rdata_q <= ram_rdata_i;
         end
      end
   end

   assign rom_addr_o   = addr_q[CODE_AW-1:0];
   assign ram_addr_o   = addr_q[XDATA_AW-1:0];
   assign ram_wdata_o  = wdata_q;
   assign mem_if.rdata = rdata_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_mc8051_mem_ctrl.sv
// Scoreboard bench for mc8051_mem_ctrl with behavioural sync ROM/XRAM models.
module tb_mc8051_mem_ctrl;

   localparam int CAW = 12;
   localparam int XAW = 11;
   localparam int CW  = 0;
   localparam int XW  = 2;
   localparam int K_CODE = 0;
   localparam int K_XRD  = 1;
   localparam int K_XWR  = 2;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           rom_en, ram_en, ram_we, err;
   logic [CAW-1:0] rom_addr;
   logic [XAW-1:0] ram_addr;
   logic [7:0]     ram_wdata, rom_rdata, ram_rdata;

   mc8051_mem_ctrl_if bus ();

   mc8051_mem_ctrl #(
      .CODE_AW(CAW), .XDATA_AW(XAW), .CODE_WAIT(CW), .XDATA_WAIT(XW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_if      (bus),
      .rom_en_o    (rom_en),
      .rom_addr_o  (rom_addr),
      .rom_rdata_i (rom_rdata),
      .ram_en_o    (ram_en),
      .ram_we_o    (ram_we),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_val(input logic [CAW-1:0] a);
      if (a == 12'h123) return 8'hA5;
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   logic [7:0] ram [2048];
   always @(posedge clk) begin
      if (rom_en) rom_rdata <= rom_val(rom_addr);
      if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
      else if (ram_en)      ram_rdata <= ram[ram_addr];
   end

   int cyc, rom_n, ram_n, we_cnt, rom_at, ram_at;
   logic [CAW-1:0] rom_a;
   logic [XAW-1:0] ram_a;
   logic [7:0]     ram_d;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rom_en) begin rom_n <= rom_n + 1; rom_at <= cyc; rom_a <= rom_addr; end
      if (ram_en) begin ram_n <= ram_n + 1; ram_at <= cyc; ram_a <= ram_addr; ram_d <= ram_wdata; end
      if (ram_we) we_cnt <= we_cnt + 1;
   end

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] ref_ram [2048];
   logic [7:0] exp_last = 8'hFF;
   logic [7:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic access(input int kind, input logic [15:0] a, input logic [7:0] d,
                         input bit both_rd, input string tag);
      int w, n, t0, r0, m0, e0;
      bit inr;
      logic [7:0] exp;
      w   = (kind == K_CODE) ? CW : XW;
      inr = (kind == K_CODE) ? (a < 16'h1000) : (a < 16'h0800);
      if (kind == K_CODE)     exp = inr ? rom_val(a[CAW-1:0]) : 8'hFF;
      else if (kind == K_XRD) exp = inr ? ref_ram[a[XAW-1:0]] : 8'hFF;
      else                    exp = exp_last;
      @(negedge clk);
      bus.psen_n = !(kind == K_CODE);
      bus.rd_n   = !(kind == K_XRD || both_rd);
      bus.we_n   = !(kind == K_XWR);
      bus.addr   = a;
      bus.wdata  = d;
      sb.push_back(exp);
      if (kind == K_XWR && inr) ref_ram[a[XAW-1:0]] = d;
      t0 = cyc; r0 = rom_n; m0 = ram_n; e0 = we_cnt;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.data_rdy && n < 40);
      chk({tag, "_lat"}, n, w + 3);
      chk({tag, "_rdata"}, bus.rdata, sb.pop_front());
      exp_last = exp;
      chk({tag, "_rom_n"}, rom_n - r0, (kind == K_CODE && inr) ? 1 : 0);
      chk({tag, "_ram_n"}, ram_n - m0, (kind != K_CODE && inr) ? 1 : 0);
      chk({tag, "_we_n"},  we_cnt - e0, (kind == K_XWR && inr) ? 1 : 0);
      if (inr && kind == K_CODE) begin
         chk({tag, "_en_t"}, rom_at - t0, w + 1);
         chk({tag, "_rom_a"}, rom_a, a[CAW-1:0]);
      end
      if (inr && kind != K_CODE) begin
         chk({tag, "_en_t"}, ram_at - t0, w + 1);
         chk({tag, "_ram_a"}, ram_a, a[XAW-1:0]);
         if (kind == K_XWR) chk({tag, "_wdata"}, ram_d, d);
      end
      @(posedge clk); #1;
      chk({tag, "_hold"}, bus.data_rdy, 1'b1);
      @(negedge clk);
      bus.psen_n = 1'b1; bus.rd_n = 1'b1; bus.we_n = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_rel"}, bus.data_rdy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, m0, e0, n;
      logic seen;
      logic [15:0] ra;
      logic [7:0]  rd;
      reset_n = 1'b0;
      bus.psen_n = 1'b1; bus.rd_n = 1'b1; bus.we_n = 1'b1;
      bus.addr = '0; bus.wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", bus.rdata, 8'hFF);
      chk("rst_rdy", bus.data_rdy, 1'b0);
      chk("rst_en", {rom_en, ram_en, ram_we}, 3'b000);
      chk("rst_err", err, 1'b0);
      chk("rst_addr", {rom_addr, ram_addr}, '0);
      @(negedge clk); reset_n = 1'b1;
      r0 = rom_n; m0 = ram_n;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_rdy", bus.data_rdy, 1'b0);
      chk("idle_en", (rom_n - r0) + (ram_n - m0), 0);

      // Fetch with zero wait states
      access(K_CODE, 16'h0123, 8'h00, 1'b0, "fetch123");
      for (int i = 0; i < 3; i++) access(K_CODE, 16'($urandom_range(0, 4095)), 8'h00, 1'b0, "fetch_rnd");
      access(K_CODE, 16'h0FFF, 8'h00, 1'b0, "fetch_top");

      // XRAM write then read back
      access(K_XWR, 16'h0010, 8'h3C, 1'b0, "wr10");
      chk("wr_keeps_rdata", bus.rdata, exp_last);
      access(K_XRD, 16'h0010, 8'h00, 1'b0, "rd10");
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom_range(0, 2047));
         rd = 8'($urandom);
         access(K_XWR, ra, rd, 1'b0, "wr_rnd");
         access(K_XRD, ra, 8'h00, 1'b0, "rd_rnd");
      end
      access(K_XWR, 16'h07FF, 8'h81, 1'b0, "wr_top");
      access(K_XRD, 16'h07FF, 8'h00, 1'b0, "rd_top");

      // Out of range
      access(K_XRD, 16'h0900, 8'h00, 1'b0, "rd_oor");
      access(K_CODE, 16'h1234, 8'h00, 1'b0, "fetch_oor");
      access(K_XWR, 16'h0000, 8'h5D, 1'b0, "wr0");
      access(K_XWR, 16'h0800, 8'hC3, 1'b0, "wr_oor");
      access(K_XRD, 16'h0000, 8'h00, 1'b0, "rd0_alias");
      chk("err_before_coll", err, 1'b0);

      // Collision: PSEN wins, error is sticky
      access(K_CODE, 16'h0456, 8'h00, 1'b1, "coll");
      chk("coll_err", err, 1'b1);

      // Abort during WAIT
      @(negedge clk);
      bus.rd_n = 1'b0; bus.addr = 16'h0010;
      m0 = ram_n; seen = 1'b0;
      @(negedge clk);
      bus.rd_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen |= bus.data_rdy;
      end
      chk("abort_rdy", seen, 1'b0);
      chk("abort_ram_n", ram_n - m0, 0);
      chk("abort_rdata", bus.rdata, exp_last);
      chk("abort_err_sticky", err, 1'b1);
      access(K_XRD, 16'h0010, 8'h00, 1'b0, "post_abort");

      // Reset during ISSUE of a write
      access(K_XWR, 16'h0020, 8'h11, 1'b0, "wr20");
      @(negedge clk);
      bus.we_n = 1'b0; bus.addr = 16'h0020; bus.wdata = 8'hEE;
      e0 = we_cnt; n = 0;
      do begin @(posedge clk); #1; n++; end while (!ram_en && n < 10);
      chk("mid_issue_seen", ram_en, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_en", {rom_en, ram_en, ram_we}, 3'b000);
      chk("mid_rst_rdy", bus.data_rdy, 1'b0);
      chk("mid_rst_rdata", bus.rdata, 8'hFF);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_out", {ram_addr, ram_wdata}, '0);
      @(negedge clk); bus.we_n = 1'b1;
      @(negedge clk); reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_we", we_cnt - e0, 0);
      exp_last = 8'hFF;
      access(K_XRD, 16'h0020, 8'h00, 1'b0, "rd20_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
